ahb_interconnect: RTL and testbench

Parametrised single-master AHB-Lite interconnect with NUM_SLAVES slave ports selected by a programmable address field. It decodes address phases, tracks the data phase across wait states, and muxes the response. An internal default slave returns a two-cycle ERROR for unmapped regions, and a saturating counter tracks decode errors. It sits between the core's bus master and the memory/peripheral slaves.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_default_slave.sv | 62 ++++++
 rtl/ahb_interconnect.sv | 101 ++++++++++
 tb/tb_ahb_interconnect.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the
// interconnect slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped regions: two-cycle ERROR response plus a
// saturating decode-error counter.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        capture,
  input  logic        hit,
  output logic        hready,
  output logic        hresp,
  output logic [15:0] err_cnt
);

  ds_state_e state, state_nxt;
  logic      enter_err;

  always_ff @(posedge hclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, matching the hardware regardless of block ordering.
    if (!hreset_n) begin
      state   <= DS_IDLE;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (enter_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt = state;
    enter_err = 1'b0;
    hready    = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state)
      DS_IDLE: begin
        if (capture && hit) begin
          state_nxt = DS_ERR1;
          enter_err = 1'b1;
        end
      end
      DS_ERR1: begin
        hready    = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        hresp = HRESP_ERROR;
        if (capture && hit) begin
          state_nxt = DS_ERR1;
          enter_err = 1'b1;
        end else begin
          state_nxt = DS_IDLE;
        end
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: region decode, data-phase tracking
// and response mux, with a default slave for unmapped regions.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int                    NUM_SLAVES = 4,
  parameter int                    SEL_LSB    = 28,
  parameter int                    SEL_W      = 2,
  parameter logic [NUM_SLAVES-1:0] SLV_EN     = '1
) (
  input  logic                     hclk,
  input  logic                     hreset_n,
  input  logic [31:0]              haddr_m,
  input  logic [2:0]               hsize_m,
  input  logic                     hwrite_m,
  input  logic [1:0]               htrans_m,
  input  logic [31:0]              hwdata_m,
  output logic [31:0]              hrdata_m,
  output logic                     hready_m,
  output logic                     hresp_m,
  output logic [31:0]              haddr_s,
  output logic [2:0]               hsize_s,
  output logic                     hwrite_s,
  output logic [1:0]               htrans_s,
  output logic [31:0]              hwdata_s,
  output logic                     hready_s,
  output logic [NUM_SLAVES-1:0]    hsel_s,
  input  logic [32*NUM_SLAVES-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]    hreadyout_s,
  input  logic [NUM_SLAVES-1:0]    hresp_s,
  output logic [15:0]              err_cnt
);

  logic [SEL_W-1:0]    region;
  logic                active;
  logic                default_hit;
  logic [NUM_SLAVES:0] dp_sel;
  logic                dp_valid;
  logic                ds_hready;
  logic                ds_hresp;

  assign haddr_s  = haddr_m;
  assign hsize_s  = hsize_m;
  assign hwrite_s = hwrite_m;
  assign htrans_s = htrans_m;
  assign hwdata_s = hwdata_m;
  assign hready_s = hready_m;

  assign region = haddr_m[SEL_LSB +: SEL_W];
  assign active = trans_active(htrans_m);

  // Compare as integers so a narrow region field never aliases a high index.
  always_comb begin
    hsel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (active && (int'(region) == i) && SLV_EN[i]) hsel_s[i] = 1'b1;
    end
  end

  assign default_hit = active && (hsel_s == '0);

  // Address phase is only accepted when the previous data phase completes.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      dp_sel   <= '0;
      dp_valid <= 1'b0;
    end else if (hready_m) begin
      dp_sel   <= {default_hit, hsel_s};
      dp_valid <= active;
    end
  end

  always_comb begin
    hrdata_m = '0;
    hready_m = 1'b1;
    hresp_m  = HRESP_OKAY;
    if (dp_valid && dp_sel[NUM_SLAVES]) begin
      hready_m = ds_hready;
      hresp_m  = ds_hresp;
    end else if (dp_valid) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dp_sel[i]) begin
          hrdata_m = hrdata_s[32*i +: 32];
          hready_m = hreadyout_s[i];
          hresp_m  = hresp_s[i];
        end
      end
    end
  end

  ahb_default_slave u_default_slave (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .capture  (hready_m),
    .hit      (default_hit),
    .hready   (ds_hready),
    .hresp    (ds_hresp),
    .err_cnt  (err_cnt)
  );

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect with three slave ports, so region 3
// is unmapped and exercises the default slave.
module tb_ahb_interconnect;

  localparam int NS = 3;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic [31:0]   haddr_m;
  logic [2:0]    hsize_m;
  logic          hwrite_m;
  logic [1:0]    htrans_m;
  logic [31:0]   hwdata_m;
  logic [31:0]   hrdata_m;
  logic          hready_m;
  logic          hresp_m;
  logic [31:0]   haddr_s;
  logic [2:0]    hsize_s;
  logic          hwrite_s;
  logic [1:0]    htrans_s;
  logic [31:0]   hwdata_s;
  logic          hready_s;
  logic [NS-1:0] hsel_s;
  logic [32*NS-1:0] hrdata_s;
  logic [NS-1:0] hreadyout_s;
  logic [NS-1:0] hresp_s;
  logic [15:0]   err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_interconnect #(
    .NUM_SLAVES (NS),
    .SEL_LSB    (28),
    .SEL_W      (2),
    .SLV_EN     (3'b111)
  ) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .haddr_m     (haddr_m),
    .hsize_m     (hsize_m),
    .hwrite_m    (hwrite_m),
    .htrans_m    (htrans_m),
    .hwdata_m    (hwdata_m),
    .hrdata_m    (hrdata_m),
    .hready_m    (hready_m),
    .hresp_m     (hresp_m),
    .haddr_s     (haddr_s),
    .hsize_s     (hsize_s),
    .hwrite_s    (hwrite_s),
    .htrans_s    (htrans_s),
    .hwdata_s    (hwdata_s),
    .hready_s    (hready_s),
    .hsel_s      (hsel_s),
    .hrdata_s    (hrdata_s),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .err_cnt     (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 2 ns later.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_slave(input int idx, input logic [31:0] data,
                           input logic rdy, input logic rsp);
    hrdata_s[32*idx +: 32] = data;
    hreadyout_s[idx]       = rdy;
    hresp_s[idx]           = rsp;
  endtask

  initial begin
    hreset_n = 1'b0;
    haddr_m  = 32'h1000_0000;
    hsize_m  = 3'b010;
    hwrite_m = 1'b0;
    htrans_m = 2'b10;
    hwdata_m = 32'h0;
    set_slave(0, 32'h1111_1111, 1'b1, 1'b0);
    set_slave(1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    set_slave(2, 32'h2222_2222, 1'b1, 1'b0);

    // Reset held three cycles while the master presents NONSEQ.
    repeat (3) tick();
    #2;
    check("rst_hready", 32'(hready_m), 32'd1);
    check("rst_hresp",  32'(hresp_m),  32'd0);
    check("rst_hrdata", hrdata_m,      32'h0);
    check("rst_errcnt", 32'(err_cnt),  32'd0);

    tick();
    hreset_n = 1'b1;
    htrans_m = 2'b00;

    // Zero-wait read from slave 1.
    tick();
    haddr_m  = 32'h1000_0004;
    htrans_m = 2'b10;
    #2;
    check("rd1_hsel",   32'(hsel_s),   32'b010);
    check("rd1_aready", 32'(hready_m), 32'd1);
    check("pass_haddr", haddr_s,       32'h1000_0004);
    tick();
    htrans_m = 2'b00;
    #2;
    check("rd1_data",   hrdata_m,      32'hDEAD_BEEF);
    check("rd1_ready",  32'(hready_m), 32'd1);
    check("rd1_hsel0",  32'(hsel_s),   32'b000);
    tick();
    #2;
    check("idle_data",  hrdata_m,      32'h0);

    // Slave 2 stalls three cycles with a slave-0 transfer pending.
    haddr_m  = 32'h2000_0000;
    htrans_m = 2'b10;
    #1;
    check("ws_hsel2",   32'(hsel_s),   32'b100);
    tick();
    set_slave(2, 32'h5555_5555, 1'b0, 1'b0);
    haddr_m  = 32'h0000_0000;
    for (int w = 0; w < 3; w++) begin
      #2;
      check("ws_low",   32'(hready_m), 32'd0);
      check("ws_hsel0", 32'(hsel_s),   32'b001);
      tick();
    end
    set_slave(2, 32'hCAFE_F00D, 1'b1, 1'b0);
    #2;
    check("ws_done",    32'(hready_m), 32'd1);
    check("ws_data2",   hrdata_m,      32'hCAFE_F00D);
    tick();
    htrans_m = 2'b00;
    #2;
    check("ws_data0",   hrdata_m,      32'h1111_1111);

    // Slave ERROR passes through without counting.
    tick();
    haddr_m  = 32'h1000_0008;
    htrans_m = 2'b10;
    tick();
    htrans_m = 2'b00;
    set_slave(1, 32'h0, 1'b0, 1'b1);
    #2;
    check("serr1_rdy",  32'(hready_m), 32'd0);
    check("serr1_rsp",  32'(hresp_m),  32'd1);
    tick();
    set_slave(1, 32'h0, 1'b1, 1'b1);
    #2;
    check("serr2_rdy",  32'(hready_m), 32'd1);
    check("serr2_rsp",  32'(hresp_m),  32'd1);
    check("serr_cnt",   32'(err_cnt),  32'd0);
    tick();
    set_slave(1, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Unmapped region 3, then a back-to-back second unmapped access.
    haddr_m  = 32'h3000_0000;
    htrans_m = 2'b10;
    #2;
    check("um_hsel",    32'(hsel_s),   32'b000);
    check("um_aready",  32'(hready_m), 32'd1);
    tick();
    haddr_m  = 32'h3000_0010;
    #2;
    check("um1_rdy",    32'(hready_m), 32'd0);
    check("um1_rsp",    32'(hresp_m),  32'd1);
    check("um1_data",   hrdata_m,      32'h0);
    check("um1_cnt",    32'(err_cnt),  32'd1);
    tick();
    #2;
    check("um2_rdy",    32'(hready_m), 32'd1);
    check("um2_rsp",    32'(hresp_m),  32'd1);
    tick();
    htrans_m = 2'b00;
    #2;
    check("um3_rdy",    32'(hready_m), 32'd0);
    check("um3_rsp",    32'(hresp_m),  32'd1);
    check("um3_cnt",    32'(err_cnt),  32'd2);

    // Reset during ERR1 returns straight to idle, no ERR2 cycle.
    hreset_n = 1'b0;
    tick();
    #2;
    check("rerr_rdy",   32'(hready_m), 32'd1);
    check("rerr_rsp",   32'(hresp_m),  32'd0);
    check("rerr_cnt",   32'(err_cnt),  32'd0);
    check("rerr_data",  hrdata_m,      32'h0);

    // Normal traffic resumes after reset.
    tick();
    hreset_n = 1'b1;
    tick();
    haddr_m  = 32'h0000_0040;
    htrans_m = 2'b11;
    tick();
    htrans_m = 2'b00;
    #2;
    check("post_data",  hrdata_m,      32'h1111_1111);
    check("post_rsp",   32'(hresp_m),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
